// File: rtl/bf_io_port_pkg.sv
// Shared definitions for the byte-wide CPU I/O port: transfer direction codes
// and the handshake FSM state encoding.
package bf_io_port_pkg;

  localparam logic DIRECTION_READ  = 1'b0;
  localparam logic DIRECTION_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2,
    ACK     = 2'd3
  } io_state_e;

endpackage

// File: rtl/bf_sync_fifo.sv
// Single-clock byte FIFO with occupancy count; simultaneous push and pop are
// both honoured, including a push into a full FIFO that is popped that cycle.
module bf_sync_fifo #(
  parameter int  FIFO_DEPTH = 16,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count alone define which
  // entries are valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bf_io_port.sv
// CPU-facing byte I/O port: a request/acknowledge handshake in front of a TX
// FIFO drained by the host and an RX FIFO filled by the host.
module bf_io_port
  import bf_io_port_pkg::*;
#(
  parameter int  FIFO_DEPTH = 16,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          io_req,
  input  logic          io_dir,
  input  logic [7:0]    io_wdata,
  output logic          io_ack,
  output logic [7:0]    io_rdata,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [7:0]    tx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic [7:0]    rx_data,
  output logic [CW-1:0] tx_count,
  output logic [CW-1:0] rx_count
);

  io_state_e  state;
  io_state_e  state_nxt;
  logic       tx_push;
  logic       tx_pop;
  logic       tx_full;
  logic       tx_empty;
  logic       rx_push;
  logic       rx_pop;
  logic       rx_full;
  logic       rx_empty;
  logic [7:0] rx_head;

  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid & rx_ready;

  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned and a latch can never be inferred.
  always_comb begin
    state_nxt = state;
    tx_push   = 1'b0;
    rx_pop    = 1'b0;
    case (state)
      IDLE: begin
        if (io_req) begin
          if (io_dir == DIRECTION_WRITE) begin
            if (!tx_full) begin
              tx_push   = 1'b1;
              state_nxt = ACK;
            end else begin
              state_nxt = WR_WAIT;
            end
          end else begin
            if (!rx_empty) begin
              rx_pop    = 1'b1;
              state_nxt = ACK;
            end else begin
              state_nxt = RD_WAIT;
            end
          end
        end
      end
      // A host drain in the same cycle frees the slot a full FIFO needs.
      WR_WAIT: begin
        if (!io_req) begin
          state_nxt = IDLE;
        end else if (!tx_full || tx_pop) begin
          tx_push   = 1'b1;
          state_nxt = ACK;
        end
      end
      RD_WAIT: begin
        if (!io_req) begin
          state_nxt = IDLE;
        end else if (!rx_empty) begin
          rx_pop    = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (!io_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      io_ack   <= 1'b0;
      io_rdata <= '0;
    end else begin
      state  <= state_nxt;
      io_ack <= (state_nxt == ACK);
      if (rx_pop) io_rdata <= rx_head;
    end
  end

  bf_sync_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (io_wdata),
    .pop       (tx_pop),
    .pop_data  (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  bf_sync_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rx_data),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

endmodule

// File: tb/tb_bf_io_port.sv
// Scoreboard bench for bf_io_port: directed handshake scenarios plus random
// CPU/host traffic, with byte order checked against queue-based models.
module tb_bf_io_port;
  import bf_io_port_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          io_req;
  logic          io_dir;
  logic [7:0]    io_wdata;
  logic          io_ack;
  logic [7:0]    io_rdata;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    tx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    rx_data;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] rx_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model contents: bytes the CPU has issued for TX, bytes the host put in RX.
  logic [7:0] tx_exp_q[$];
  logic [7:0] rd_exp_q[$];

  logic       ack_q;
  logic       rd_pend;
  logic [7:0] rd_want;
  bit         cpu_done;

  bf_io_port #(.FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .io_req   (io_req),
    .io_dir   (io_dir),
    .io_wdata (io_wdata),
    .io_ack   (io_ack),
    .io_rdata (io_rdata),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .tx_count (tx_count),
    .rx_count (rx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one CPU transfer, wait (bounded) for io_ack, then release io_req.
  task automatic cpu_xfer(input logic dir, input logic [7:0] d);
    if (dir == DIRECTION_WRITE) tx_exp_q.push_back(d);
    io_req   = 1'b1;
    io_dir   = dir;
    io_wdata = d;
    step();
    for (int i = 0; i < 300; i++) begin
      if (io_ack) break;
      step();
    end
    check("xfer_ack_timeout", io_ack, 1);
    io_req   = 1'b0;
    io_wdata = 8'($urandom);
    step();
  endtask

  task automatic drain_tx();
    tx_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      if (!tx_valid) break;
      step();
    end
    tx_ready = 1'b0;
    check("drain_tx_valid", tx_valid, 0);
    check("drain_tx_count", tx_count, 0);
  endtask

  // Monitor: compares the TX stream and CPU read data against the models.
  always @(negedge clk) begin
    if (rst) begin
      ack_q   <= 1'b0;
      rd_pend <= 1'b0;
    end else begin
      if (rd_pend) check("io_rdata", io_rdata, rd_want);
      if (io_ack && !ack_q && io_dir == DIRECTION_READ) begin
        check("rd_model_nonempty", rd_exp_q.size() > 0, 1);
        if (rd_exp_q.size() > 0) begin
          rd_want <= rd_exp_q.pop_front();
          rd_pend <= 1'b1;
        end else begin
          rd_pend <= 1'b0;
        end
      end else begin
        rd_pend <= 1'b0;
      end
      ack_q <= io_ack;
      if (tx_valid && tx_ready) begin
        check("tx_model_nonempty", tx_exp_q.size() > 0, 1);
        if (tx_exp_q.size() > 0) check("tx_data", tx_data, tx_exp_q.pop_front());
      end
      if (rx_valid && rx_ready) rd_exp_q.push_back(rx_data);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_left;
    rst      = 1'b1;
    io_req   = 1'b0;
    io_dir   = DIRECTION_READ;
    io_wdata = '0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    cpu_done = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_io_ack", io_ack, 0);
    check("rst_io_rdata", io_rdata, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_tx_count", tx_count, 0);
    check("rst_rx_count", rx_count, 0);

    // Write into empty TX: one-cycle ack latency.
    tx_exp_q.push_back(8'h41);
    io_req = 1'b1; io_dir = DIRECTION_WRITE; io_wdata = 8'h41;
    step();
    check("wr_ack", io_ack, 1);
    check("wr_tx_valid", tx_valid, 1);
    check("wr_tx_data", tx_data, 8'h41);
    check("wr_tx_count", tx_count, 1);
    io_req = 1'b0;
    step();
    check("wr_ack_drop", io_ack, 0);
    drain_tx();

    // Read from empty RX: stall until the host supplies a byte.
    io_req = 1'b1; io_dir = DIRECTION_READ;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rd_wait_ack", io_ack, 0);
    end
    rx_valid = 1'b1; rx_data = 8'h7E;
    step();
    rx_valid = 1'b0;
    check("rd_wait_rx_count", rx_count, 1);
    step();
    check("rd_ack", io_ack, 1);
    check("rd_rx_count", rx_count, 0);
    io_req = 1'b0;
    step();
    check("rd_rdata", io_rdata, 8'h7E);

    // Fill TX, then a write stalls until one host drain cycle frees a slot.
    for (int i = 0; i < DEPTH; i++) cpu_xfer(DIRECTION_WRITE, 8'(8'h10 + i));
    check("full_tx_count", tx_count, DEPTH);
    check("full_tx_valid", tx_valid, 1);
    tx_exp_q.push_back(8'h55);
    io_req = 1'b1; io_dir = DIRECTION_WRITE; io_wdata = 8'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wr_wait_ack", io_ack, 0);
    end
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check("wr_wait_done_ack", io_ack, 1);
    check("wr_wait_tx_count", tx_count, DEPTH);
    io_req = 1'b0;
    step();
    drain_tx();

    // Held request: exactly one push however long io_req stays high.
    io_req = 1'b1; io_dir = DIRECTION_WRITE; io_wdata = 8'h99;
    tx_exp_q.push_back(8'h99);
    step();
    for (int i = 0; i < 10; i++) begin
      check("held_ack", io_ack, 1);
      io_wdata = 8'($urandom);
      step();
    end
    io_req = 1'b0;
    step();
    check("held_ack_drop", io_ack, 0);
    check("held_tx_count", tx_count, 1);
    drain_tx();

    // Simultaneous RX push and CPU pop at count 1.
    rx_valid = 1'b1; rx_data = 8'hA1;
    step();
    check("sim_pre_count", rx_count, 1);
    rx_data = 8'hB2;
    io_req = 1'b1; io_dir = DIRECTION_READ;
    step();
    rx_valid = 1'b0;
    check("sim_rx_count", rx_count, 1);
    check("sim_ack", io_ack, 1);
    io_req = 1'b0;
    step();
    check("sim_rdata_a", io_rdata, 8'hA1);
    cpu_xfer(DIRECTION_READ, 8'h00);
    check("sim_rdata_b", io_rdata, 8'hB2);
    check("sim_rx_empty", rx_count, 0);

    // Request withdrawn while waiting: no pop, no ack.
    io_req = 1'b1; io_dir = DIRECTION_READ;
    step();
    step();
    io_req = 1'b0;
    step();
    check("abort_ack", io_ack, 0);
    rx_valid = 1'b1; rx_data = 8'h5A;
    step();
    rx_valid = 1'b0;
    step();
    check("abort_rx_count", rx_count, 1);
    check("abort_ack_idle", io_ack, 0);
    cpu_xfer(DIRECTION_READ, 8'h00);
    check("abort_rdata", io_rdata, 8'h5A);

    // Random concurrent CPU and host traffic.
    fork
      begin
        for (int t = 0; t < 150; t++) begin
          cpu_xfer(1'($urandom_range(0, 1)), 8'($urandom));
          repeat ($urandom_range(0, 2)) step();
        end
        cpu_done = 1'b1;
      end
      begin
        while (!cpu_done) begin
          tx_ready = ($urandom_range(0, 3) == 0);
          rx_valid = ($urandom_range(0, 3) == 0);
          rx_data  = 8'($urandom);
          step();
        end
        tx_ready = 1'b0;
        rx_valid = 1'b0;
      end
    join
    step();
    drain_tx();
    check("rand_rx_count", rx_count, rd_exp_q.size());
    n_left = rd_exp_q.size();
    for (int i = 0; i < n_left; i++) cpu_xfer(DIRECTION_READ, 8'h00);
    step();
    check("rand_rx_empty", rx_count, 0);

    // Reset while waiting on an empty RX with TX holding data.
    cpu_xfer(DIRECTION_WRITE, 8'h33);
    io_req = 1'b1; io_dir = DIRECTION_READ;
    repeat (3) step();
    rst = 1'b1;
    io_req = 1'b0;
    tx_exp_q.delete();
    rd_exp_q.delete();
    step();
    rst = 1'b0;
    check("rst2_ack", io_ack, 0);
    check("rst2_tx_count", tx_count, 0);
    check("rst2_rx_count", rx_count, 0);
    check("rst2_tx_valid", tx_valid, 0);
    check("rst2_rdata", io_rdata, 0);
    tx_exp_q.push_back(8'h01);
    io_req = 1'b1; io_dir = DIRECTION_WRITE; io_wdata = 8'h01;
    step();
    check("post_rst_ack", io_ack, 1);
    check("post_rst_tx_data", tx_data, 8'h01);
    check("post_rst_tx_count", tx_count, 1);
    io_req = 1'b0;
    step();
    drain_tx();

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bf_io_port.md
BF_IO_PORT -- requirements
Module: bf_io_port

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning entries per FIFO; power of two, at least 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port io_req, input, 1 bit: CPU request, level-held until acknowledged.
REQ-005 SHALL have port io_dir, input, 1 bit: transfer direction, DIRECTION_READ=0, DIRECTION_WRITE=1.
REQ-006 SHALL have port io_wdata, input, 8 bits: output byte, valid while io_req=1 and io_dir=WRITE.
REQ-007 SHALL have port io_ack, output, 1 bit: transfer acknowledge.
REQ-008 SHALL have port io_rdata, output, 8 bits: input byte returned to the CPU.
REQ-009 SHALL have ports tx_valid (output, 1), tx_ready (input, 1) and tx_data (output, 8): host-side drain stream for the TX FIFO.
REQ-010 SHALL have ports rx_valid (input, 1), rx_ready (output, 1) and rx_data (input, 8): host-side fill stream for the RX FIFO.
REQ-011 SHALL have ports tx_count and rx_count, outputs, each $clog2(FIFO_DEPTH)+1 bits: current occupancy of each FIFO.

Function
REQ-012 SHALL implement the FSM states IDLE, WR_WAIT, RD_WAIT and ACK, with the state register updated on posedge clk.
REQ-013 In IDLE with io_req=1 and io_dir=WRITE: if TX is not full, SHALL push io_wdata and go to ACK; if TX is full, SHALL go to WR_WAIT.
REQ-014 In IDLE with io_req=1 and io_dir=READ: if RX is not empty, SHALL pop the head into io_rdata and go to ACK; if RX is empty, SHALL go to RD_WAIT.
REQ-015 WR_WAIT and RD_WAIT SHALL complete the pending push or pop on the first cycle the resource becomes available, then go to ACK; io_ack stays 0 while waiting.
REQ-016 io_ack SHALL be registered and equal 1 exactly while the state is ACK; latency is 1 cycle from an io_req sample with the resource available to io_ack=1.
REQ-017 io_rdata SHALL hold its value from the pop until the next pop; the CPU samples it one cycle after io_ack rises.
REQ-018 ACK SHALL go to IDLE on the first cycle io_req=0; exactly one push or pop occurs per request, however long io_req stays high.
REQ-019 If io_req drops during WR_WAIT or RD_WAIT, the FSM SHALL return to IDLE with no push, no pop and no ack.
REQ-020 tx_valid SHALL equal TX not empty; tx_data SHALL equal the TX head; a pop occurs when tx_valid and tx_ready are both 1.
REQ-021 rx_ready SHALL equal RX not full; a push of rx_data occurs when rx_valid and rx_ready are both 1.
REQ-022 A push and a pop on the same FIFO in the same cycle SHALL both take effect, leaving the count unchanged; this is legal when full (WR_WAIT then proceeds) and when the count is 1.
REQ-023 FIFO pointers SHALL be $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; counts SHALL range from 0 to FIFO_DEPTH inclusive.
REQ-024 io_wdata and io_dir SHALL be ignored when io_req=0; the block SHALL not start a new transfer while in ACK.

Reset
REQ-025 While rst=1 at a posedge: state=IDLE, io_ack=0, io_rdata=0, both FIFOs empty (tx_valid=0, rx_ready=1), counts=0.
REQ-026 Reset mid-transfer SHALL abandon the transfer; FIFO contents are discarded; the first request after rst falls is handled as new.

Structure
REQ-027 FSM state encodings SHALL live in a shared macros header for io_port states; DIRECTION_READ and DIRECTION_WRITE SHALL come from the existing shared direction macros header.
REQ-028 A sub-module bf_sync_fifo (8-bit data, parameter FIFO_DEPTH, push/pop/full/empty/count) SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-029 Write with TX empty: io_req=1, dir=WRITE, wdata=0x41 -> io_ack=1 next cycle, tx_valid=1, tx_data=0x41, tx_count=1; io_req=0 -> io_ack=0 next cycle.
REQ-030 Read with RX empty: io_req=1, dir=READ, no rx data for 5 cycles -> io_ack stays 0; rx_valid pulse with 0x7E -> io_ack=1, then io_rdata=0x7E, rx_count returns to 0.
REQ-031 TX full: 16 writes with tx_ready=0, then a 17th write (0x55) -> stall in WR_WAIT; one cycle of tx_ready=1 -> 0x55 is pushed, io_ack=1, tx_count=16.
REQ-032 Held request: io_req held 10 cycles after io_ack -> exactly one push, and io_ack stays 1 throughout.
REQ-033 Simultaneous traffic: RX push and CPU pop in the same cycle with rx_count=1 -> rx_count stays 1 and data order is preserved.
REQ-034 Reset during RD_WAIT -> io_ack=0 and counts=0; after release, a write of 0x01 completes normally.
